trn_tx_arb: RTL

- Round-robin arbiter that shares the PCIe core's single TRN transmit interface between NREQ local packet sources (DMA engine, CSR-driven test generator, etc.).
- Grants at TLP boundaries only and services the core's configuration-TLP request/grant handshake.
- Sits between the requesters and the transmit inputs of the PCIe wrapper, in the trn_clk domain.

---
 rtl/trn_pkg.sv | 22 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/trn_tx_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/trn_pkg.sv
// trn_pkg: shared definitions for the TRN transmit arbiter slice.
//   - trn_state_e   : arbiter FSM state encoding
//   - TRN_DW        : TRN data width
//   - TRN_TBUF_AV_W : width of the core's trn_tbuf_av field
//   - wrap_inc      : modulo-n increment used for round-robin pointers
package trn_pkg;

  localparam int TRN_DW        = 64;
  localparam int TRN_TBUF_AV_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_PKT  = 2'd2
  } trn_state_e;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping modulo N.
// Ports:
//   req     in  N   request vector
//   ptr     in  PW  search start index (must be < N)
//   win     out N   one-hot winner (zero when no request)
//   win_idx out PW  binary index of the winner
//   any     out 1   at least one request present
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  logic [2*N-1:0] req2_s;
  logic           hit_s;
  logic           found_s;
  int             idx_s;

  // Doubling the vector lets a plain offset walk cover the wrap-around.
  assign req2_s = {req, req};

  // Walk offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      hit_s   = |(req2_s & ({{(2*N-1){1'b0}}, 1'b1} << (int'(ptr) + k)));
      idx_s   = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      found_s = any;
      any     = any | hit_s;
      win_idx = (hit_s && !found_s) ? PW'(idx_s) : win_idx;
    end
  end

  assign win = any ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;

endmodule

// File: rtl/trn_tx_arb.sv
// trn_tx_arb: round-robin arbiter sharing the PCIe core's TRN transmit
// interface between NREQ local packet sources. Ownership changes only at
// TLP boundaries; the core's config-TLP slot request is serviced from IDLE
// and always wins over user requests there.
// Optional build macro TRN_TX_ARB_BUF_GATE_EN: a new grant additionally
// requires trn_tbuf_av >= BUF_MIN.
// Ports:
//   trn_clk, trn_reset_n       clock, async active-low reset
//   trn_lnk_up_n               link up (active-low); loss aborts the packet
//   req_*                      per-requester TRN Tx inputs (req_td packed 64b each)
//   req_tdst_rdy_n             per-requester ready (only the owner sees the core)
//   trn_t*                     muxed TRN Tx outputs to the core
//   trn_tdst_rdy_n, trn_tbuf_av, trn_terr_drop_n   core status
//   trn_tcfg_req_n / trn_tcfg_gnt_n                config slot handshake
//   gnt, busy                  one-hot owner and packet-in-flight status
module trn_tx_arb
  import trn_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int BUF_MIN = 1
) (
  input  logic                     trn_clk,
  input  logic                     trn_reset_n,
  input  logic                     trn_lnk_up_n,
  input  logic [NREQ*TRN_DW-1:0]   req_td,
  input  logic [NREQ-1:0]          req_trem_n,
  input  logic [NREQ-1:0]          req_tsof_n,
  input  logic [NREQ-1:0]          req_teof_n,
  input  logic [NREQ-1:0]          req_tsrc_rdy_n,
  input  logic [NREQ-1:0]          req_tsrc_dsc_n,
  input  logic [NREQ-1:0]          req_terrfwd_n,
  input  logic [NREQ-1:0]          req_tstr_n,
  output logic [NREQ-1:0]          req_tdst_rdy_n,
  output logic [TRN_DW-1:0]        trn_td,
  output logic                     trn_trem_n,
  output logic                     trn_tsof_n,
  output logic                     trn_teof_n,
  output logic                     trn_tsrc_rdy_n,
  output logic                     trn_tsrc_dsc_n,
  output logic                     trn_terrfwd_n,
  output logic                     trn_tstr_n,
  input  logic                     trn_tdst_rdy_n,
  input  logic [TRN_TBUF_AV_W-1:0] trn_tbuf_av,
  input  logic                     trn_tcfg_req_n,
  output logic                     trn_tcfg_gnt_n,
  input  logic                     trn_terr_drop_n,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  trn_state_e      state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic            busy_r, busy_s;
  logic [PW-1:0]   own_r, own_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic            cfg_gnt_n_r, cfg_gnt_n_s;

  logic [NREQ-1:0] req_vec_s;
  logic [NREQ-1:0] pick_win_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic            buf_ok_s;
  logic            eof_xfer_s;
  logic            pkt_end_s;

  // A requester asks for the link by presenting a valid start-of-frame beat.
  assign req_vec_s = ~req_tsrc_rdy_n & ~req_tsof_n;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req     (req_vec_s),
    .ptr     (ptr_r),
    .win     (pick_win_s),
    .win_idx (pick_idx_s),
    .any     (pick_any_s)
  );

`ifdef TRN_TX_ARB_BUF_GATE_EN
  assign buf_ok_s = (trn_tbuf_av >= TRN_TBUF_AV_W'(BUF_MIN));
`else
  localparam int unused_buf_min = BUF_MIN;
  logic unused_tbuf_s;
  assign unused_tbuf_s = ^trn_tbuf_av;
  assign buf_ok_s      = 1'b1;
`endif

  // Packet termination: accepted eof beat, owner discontinue, or core drop.
  assign eof_xfer_s = !req_teof_n[own_r] && !req_tsrc_rdy_n[own_r] && !trn_tdst_rdy_n;
  assign pkt_end_s  = eof_xfer_s || !req_tsrc_dsc_n[own_r] || !trn_terr_drop_n;

  // State and status registers.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_r     <= ST_IDLE;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      own_r       <= '0;
      ptr_r       <= '0;
      cfg_gnt_n_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      busy_r      <= busy_s;
      own_r       <= own_s;
      ptr_r       <= ptr_s;
      cfg_gnt_n_r <= cfg_gnt_n_s;
    end
  end

  // Next-state logic; link loss overrides everything.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    busy_s      = busy_r;
    own_s       = own_r;
    ptr_s       = ptr_r;
    cfg_gnt_n_s = 1'b1;
    if (trn_lnk_up_n) begin
      state_s = ST_IDLE;
      gnt_s   = '0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!trn_tcfg_req_n) begin
            state_s     = ST_CFG;
            cfg_gnt_n_s = 1'b0;
          end else if (pick_any_s && buf_ok_s) begin
            state_s = ST_PKT;
            gnt_s   = pick_win_s;
            own_s   = pick_idx_s;
            busy_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CFG: begin
          // The config slot lasts one cycle; user grants wait for IDLE.
          state_s = ST_IDLE;
        end
        ST_PKT: begin
          if (pkt_end_s) begin
            state_s = ST_IDLE;
            gnt_s   = '0;
            busy_s  = 1'b0;
            ptr_s   = PW'(wrap_inc(int'(own_r), NREQ));
          end else begin
            state_s = ST_PKT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          gnt_s   = '0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // Data path: the owner's beat goes straight through while a packet is open.
  always_comb begin
    trn_td         = '0;
    trn_trem_n     = 1'b1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    trn_tsrc_dsc_n = 1'b1;
    trn_terrfwd_n  = 1'b1;
    trn_tstr_n     = 1'b1;
    req_tdst_rdy_n = '1;
    if (state_r == ST_PKT) begin
      trn_td                = req_td[own_r*TRN_DW +: TRN_DW];
      trn_trem_n            = req_trem_n[own_r];
      trn_tsof_n            = req_tsof_n[own_r];
      trn_teof_n            = req_teof_n[own_r];
      trn_tsrc_rdy_n        = req_tsrc_rdy_n[own_r];
      trn_tsrc_dsc_n        = req_tsrc_dsc_n[own_r];
      trn_terrfwd_n         = req_terrfwd_n[own_r];
      trn_tstr_n            = req_tstr_n[own_r];
      req_tdst_rdy_n[own_r] = trn_tdst_rdy_n;
    end else begin
      trn_td = '0;
    end
  end

  assign gnt            = gnt_r;
  assign busy           = busy_r;
  assign trn_tcfg_gnt_n = cfg_gnt_n_r;

endmodule
